// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement queue. Entries are dispatched at
// the tail, marked done out of order, and popped from the head one per cycle.
// Each retirement releases the superseded physical tag back to the free list.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 6,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_valid,
  input  logic [4:0]       dispatch_rd,
  input  logic [TAG_W-1:0] dispatch_prd,
  input  logic [TAG_W-1:0] dispatch_prd_old,
  output logic             dispatch_ready,
  output logic [IDX_W-1:0] dispatch_idx,
  input  logic             complete_valid,
  input  logic [IDX_W-1:0] complete_idx,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [TAG_W-1:0] commit_prd,
  output logic             commit_free,
  output logic [TAG_W-1:0] commit_tag,
  output logic [IDX_W:0]   count,
  output logic             empty
);

  localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

  // Per-entry control bits and payload
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] done_q;
  logic [4:0]       rd_q   [DEPTH];
  logic [TAG_W-1:0] prd_q  [DEPTH];
  logic [TAG_W-1:0] old_q  [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   cnt;
  logic [IDX_W:0]   cnt_n;
  logic             do_disp;
  logic             do_commit;

  // Full/empty come from the occupancy counter only, never from head==tail.
  // Ready is not bypassed by a same-cycle commit: a full queue drops dispatch.
  assign dispatch_ready = (cnt != FULL_CNT);
  assign dispatch_idx   = tail;
  assign count          = cnt;
  assign empty          = (cnt == '0);
  assign commit_free    = commit_valid && (commit_rd != 5'd0);

  // Flush overrides every other operation on the same edge.
  assign do_disp   = dispatch_valid && dispatch_ready && !flush;
  assign do_commit = valid_q[head] && done_q[head] && !flush;

  // Occupancy update: a simultaneous dispatch and commit leave it unchanged
  always_comb begin
    cnt_n = cnt;
    case ({do_disp, do_commit})
      2'b10:   cnt_n = cnt + (IDX_W + 1)'(1);
      2'b01:   cnt_n = cnt - (IDX_W + 1)'(1);
      default: cnt_n = cnt;
    endcase
  end

  // Queue control: pointers, count, valid/done bits and the commit pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= '0;
      done_q       <= '0;
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      commit_valid <= 1'b0;
    end else if (flush) begin
      valid_q      <= '0;
      done_q       <= '0;
      head         <= '0;
      tail         <= '0;
      cnt          <= '0;
      commit_valid <= 1'b0;
    end else begin
      // Completion to an invalid slot is ignored; the head is popped using the
      // pre-edge done bit, so a same-edge completion of the head waits a cycle.
      if (complete_valid && valid_q[complete_idx]) begin
        done_q[complete_idx] <= 1'b1;
      end
      if (do_commit) begin
        valid_q[head] <= 1'b0;
        done_q[head]  <= 1'b0;
        head          <= head + IDX_W'(1);
      end
      // The tail slot is never valid when a dispatch is accepted, so this
      // write cannot collide with a completion or a commit of a live entry.
      if (do_disp) begin
        valid_q[tail] <= 1'b1;
        done_q[tail]  <= 1'b0;
        tail          <= tail + IDX_W'(1);
      end
      cnt          <= cnt_n;
      commit_valid <= do_commit;
    end
  end

  // Entry payload; gated by valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (do_disp) begin
      rd_q[tail]  <= dispatch_rd;
      prd_q[tail] <= dispatch_prd;
      old_q[tail] <= dispatch_prd_old;
    end
  end

  // Registered retirement fields presented during the cycle after the pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_rd  <= '0;
      commit_prd <= '0;
      commit_tag <= '0;
    end else if (do_commit) begin
      commit_rd  <= rd_q[head];
      commit_prd <= prd_q[head];
      commit_tag <= old_q[head];
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: single in-order retirement, out-of-order
// completion, full/wrap, x0 destination, dispatch on commit edge, flush and
// asynchronous reset.
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int TAG_W = 6;
  localparam int IDX_W = $clog2(DEPTH);

  logic             clk;
  logic             rst;
  logic             flush;
  logic             dispatch_valid;
  logic [4:0]       dispatch_rd;
  logic [TAG_W-1:0] dispatch_prd;
  logic [TAG_W-1:0] dispatch_prd_old;
  logic             dispatch_ready;
  logic [IDX_W-1:0] dispatch_idx;
  logic             complete_valid;
  logic [IDX_W-1:0] complete_idx;
  logic             commit_valid;
  logic [4:0]       commit_rd;
  logic [TAG_W-1:0] commit_prd;
  logic             commit_free;
  logic [TAG_W-1:0] commit_tag;
  logic [IDX_W:0]   count;
  logic             empty;

  int nvec;
  int nerr;

  reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .dispatch_valid   (dispatch_valid),
    .dispatch_rd      (dispatch_rd),
    .dispatch_prd     (dispatch_prd),
    .dispatch_prd_old (dispatch_prd_old),
    .dispatch_ready   (dispatch_ready),
    .dispatch_idx     (dispatch_idx),
    .complete_valid   (complete_valid),
    .complete_idx     (complete_idx),
    .commit_valid     (commit_valid),
    .commit_rd        (commit_rd),
    .commit_prd       (commit_prd),
    .commit_free      (commit_free),
    .commit_tag       (commit_tag),
    .count            (count),
    .empty            (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [4:0] rd, input logic [TAG_W-1:0] prd, input logic [TAG_W-1:0] old);
    dispatch_valid   = 1'b1;
    dispatch_rd      = rd;
    dispatch_prd     = prd;
    dispatch_prd_old = old;
    tick();
    dispatch_valid   = 1'b0;
  endtask

  task automatic comp(input logic [IDX_W-1:0] idx);
    complete_valid = 1'b1;
    complete_idx   = idx;
    tick();
    complete_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b0;
    flush = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_rd = '0;
    dispatch_prd = '0;
    dispatch_prd_old = '0;
    complete_valid = 1'b0;
    complete_idx = '0;
    tick();
    tick();

    // Reset state
    chk("rst_cvalid", 32'(commit_valid), 0);
    chk("rst_cfree",  32'(commit_free), 0);
    chk("rst_crd",    32'(commit_rd), 0);
    chk("rst_cprd",   32'(commit_prd), 0);
    chk("rst_ctag",   32'(commit_tag), 0);
    chk("rst_ready",  32'(dispatch_ready), 1);
    chk("rst_idx",    32'(dispatch_idx), 0);
    chk("rst_count",  32'(count), 0);
    chk("rst_empty",  32'(empty), 1);
    rst = 1'b1;
    tick();

    // Single entry: dispatch N, complete N+1, commit N+2
    disp(5'd2, 6'd32, 6'd2);
    chk("t1_count",  32'(count), 1);
    chk("t1_idx",    32'(dispatch_idx), 1);
    chk("t1_empty",  32'(empty), 0);
    chk("t1_cv0",    32'(commit_valid), 0);
    comp(4'd0);
    chk("t1_cv1",    32'(commit_valid), 0);
    tick();
    chk("t1_cv2",    32'(commit_valid), 1);
    chk("t1_rd",     32'(commit_rd), 2);
    chk("t1_prd",    32'(commit_prd), 32);
    chk("t1_free",   32'(commit_free), 1);
    chk("t1_tag",    32'(commit_tag), 2);
    chk("t1_empty2", 32'(empty), 1);
    tick();
    chk("t1_cv3",    32'(commit_valid), 0);

    // Out-of-order completion: entries at idx 1,2,3 completed 3,2,1
    disp(5'd1, 6'd10, 6'd20);
    disp(5'd2, 6'd11, 6'd21);
    disp(5'd3, 6'd12, 6'd22);
    chk("t2_count", 32'(count), 3);
    comp(4'd3);
    chk("t2_cv_a", 32'(commit_valid), 0);
    comp(4'd2);
    chk("t2_cv_b", 32'(commit_valid), 0);
    comp(4'd1);
    chk("t2_cv_c", 32'(commit_valid), 0);
    tick();
    chk("t2_cv1",  32'(commit_valid), 1);
    chk("t2_rd1",  32'(commit_rd), 1);
    chk("t2_tag1", 32'(commit_tag), 20);
    tick();
    chk("t2_cv2",  32'(commit_valid), 1);
    chk("t2_rd2",  32'(commit_rd), 2);
    chk("t2_tag2", 32'(commit_tag), 21);
    tick();
    chk("t2_cv3",  32'(commit_valid), 1);
    chk("t2_rd3",  32'(commit_rd), 3);
    chk("t2_prd3", 32'(commit_prd), 12);
    tick();
    chk("t2_cv4",  32'(commit_valid), 0);
    chk("t2_empty", 32'(empty), 1);

    // Fill to 16 from idx 0, overflow dispatch dropped, then wrap
    do_flush();
    chk("fl_idx", 32'(dispatch_idx), 0);
    for (int i = 0; i < DEPTH; i++) begin
      disp(5'(i + 1), 6'(i + 32), 6'(i));
    end
    chk("t3_count", 32'(count), 16);
    chk("t3_ready", 32'(dispatch_ready), 0);
    chk("t3_idx",   32'(dispatch_idx), 0);
    disp(5'd31, 6'd63, 6'd63);
    chk("t3_count17", 32'(count), 16);
    chk("t3_idx17",   32'(dispatch_idx), 0);
    chk("t3_cv17",    32'(commit_valid), 0);
    comp(4'd0);
    tick();
    chk("t3_cv",    32'(commit_valid), 1);
    chk("t3_rd",    32'(commit_rd), 1);
    chk("t3_prd",   32'(commit_prd), 32);
    chk("t3_tag",   32'(commit_tag), 0);
    chk("t3_count2", 32'(count), 15);
    chk("t3_ready2", 32'(dispatch_ready), 1);
    chk("t3_idx2",  32'(dispatch_idx), 0);

    // Full with head done: dispatch on commit edge is dropped
    disp(5'd17, 6'd48, 6'd16);
    chk("t5_full", 32'(count), 16);
    comp(4'd1);
    chk("t5_cv0", 32'(commit_valid), 0);
    disp(5'd30, 6'd50, 6'd51);
    chk("t5_cv",    32'(commit_valid), 1);
    chk("t5_rd",    32'(commit_rd), 2);
    chk("t5_count", 32'(count), 15);
    chk("t5_idx",   32'(dispatch_idx), 1);

    // 8 entries: dispatch and commit on the same edge keep count at 8
    do_flush();
    chk("fl_count", 32'(count), 0);
    for (int i = 0; i < 8; i++) begin
      disp(5'(i + 1), 6'(i), 6'(i + 8));
    end
    comp(4'd0);
    disp(5'd9, 6'd40, 6'd41);
    chk("t5b_cv",    32'(commit_valid), 1);
    chk("t5b_rd",    32'(commit_rd), 1);
    chk("t5b_count", 32'(count), 8);
    chk("t5b_idx",   32'(dispatch_idx), 9);

    // x0 destination commits but frees nothing
    do_flush();
    disp(5'd0, 6'd5, 6'd7);
    comp(4'd0);
    tick();
    chk("t4_cv",   32'(commit_valid), 1);
    chk("t4_free", 32'(commit_free), 0);
    chk("t4_tag",  32'(commit_tag), 7);

    // Flush with 5 entries (2 done) together with a dispatch
    do_flush();
    for (int i = 0; i < 5; i++) begin
      disp(5'(i + 1), 6'(i + 1), 6'(i + 1));
    end
    comp(4'd1);
    comp(4'd2);
    chk("t6_count5", 32'(count), 5);
    flush = 1'b1;
    disp(5'd9, 6'd9, 6'd9);
    flush = 1'b0;
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_cv",    32'(commit_valid), 0);
    chk("t6_idx",   32'(dispatch_idx), 0);
    comp(4'd0);
    tick();
    chk("t6_cv2",    32'(commit_valid), 0);
    chk("t6_count2", 32'(count), 0);

    // Asynchronous reset mid-run with the head ready to commit
    disp(5'd4, 6'd20, 6'd4);
    disp(5'd5, 6'd21, 6'd5);
    disp(5'd6, 6'd22, 6'd6);
    comp(4'd0);
    rst = 1'b0;
    #1;
    chk("ar_count", 32'(count), 0);
    chk("ar_empty", 32'(empty), 1);
    chk("ar_ready", 32'(dispatch_ready), 1);
    chk("ar_idx",   32'(dispatch_idx), 0);
    chk("ar_cv",    32'(commit_valid), 0);
    tick();
    chk("ar_cv2",   32'(commit_valid), 0);
    rst = 1'b1;
    tick();
    tick();
    chk("ar_cv3",    32'(commit_valid), 0);
    chk("ar_count2", 32'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
